// File: rtl/bin_to_dec_7seg_seq.sv
// bin_to_dec_7seg_seq
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with registered BCD and seven-segment outputs. The segment outputs
// support optional leading-zero blanking and selectable polarity.
// A value is accepted over a valid/ready handshake. The result appears
// WIDTH edges after acceptance, together with a one-cycle out_valid pulse.

module bin_to_dec_7seg_seq #(
    parameter int WIDTH          = 8,
    parameter int DIGITS         = 3,
    parameter int BLANK_LEADING  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  out_valid
);

    // Shift register holds {BCD field, remaining binary bits}.
    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    // All segments dark, in the selected polarity.
    localparam logic [7*DIGITS-1:0] SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? {(7*DIGITS){1'b1}} : '0;

    localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

    // Number of decimal digits needed for the largest WIDTH-bit value.
    function automatic int digits_needed();
        logic [WIDTH+3:0] v;
        int               n;
        v = {4'b0000, {WIDTH{1'b1}}};
        n = 0;
        for (int k = 0; k < WIDTH + 1; k++) begin
            if (v != '0) begin
                n++;
                v = v / TEN;
            end
        end
        return n;
    endfunction

    if (WIDTH < 1) begin : g_bad_width
        $error("bin_to_dec_7seg_seq: WIDTH must be at least 1");
    end

    if (DIGITS < digits_needed()) begin : g_bad_digits
        $error("bin_to_dec_7seg_seq: DIGITS too small for WIDTH");
    end

    // Active-high pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    logic [0:0]          r_state;
    logic [SW-1:0]       r_shift;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic [7*DIGITS-1:0] r_seg;
    logic                r_out_valid;

    logic [SW-1:0]       w_adj;
    logic [SW-1:0]       w_next;
    logic [4*DIGITS-1:0] w_bcd;
    logic [7*DIGITS-1:0] w_seg;

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        w_adj = r_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shift[WIDTH+4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH+4*i +: 4] = r_shift[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[SW-2:0], 1'b0};
        w_bcd  = w_next[WIDTH +: 4*DIGITS];
    end

    // Segment patterns for the post-step BCD field, with blanking and polarity.
    always_comb begin : seg_build
        logic       lead_zero;
        logic [3:0] dig;
        logic [6:0] pat;
        w_seg     = '0;
        lead_zero = 1'b1;
        dig       = '0;
        pat       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig       = w_bcd[4*i +: 4];
            lead_zero = lead_zero && (dig == 4'd0);
            if ((BLANK_LEADING != 0) && (i > 0) && lead_zero) begin
                pat = 7'h00;
            end else begin
                pat = seg_of(dig);
            end
            w_seg[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    // Handshake, conversion sequencing and result registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_seg       <= SEG_OFF;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= {{(4*DIGITS){1'b0}}, bin};
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_next;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_bcd       <= w_bcd;
                        r_seg       <= w_seg;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign bcd       = r_bcd;
    assign seg       = r_seg;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bin_to_dec_7seg_seq.sv
// Testbench for bin_to_dec_7seg_seq: three configurations, a scoreboard
// fed at acceptance and drained by a monitor on out_valid, and a
// decimal reference model built from plain integer arithmetic.

module tb_bin_to_dec_7seg_seq;

    localparam int N = 3;
    localparam int PW[N]   = '{8, 8, 16};
    localparam int PD[N]   = '{3, 3, 5};
    localparam int PBL[N]  = '{1, 0, 0};
    localparam int PSAL[N] = '{0, 1, 1};

    typedef struct packed {
        logic [19:0] bcd;
        logic [34:0] seg;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] bin_v    [N];
    logic        in_valid [N];
    logic        rdy      [N];
    logic        ov       [N];
    logic [19:0] bcd_o    [N];
    logic [34:0] seg_o    [N];

    logic [11:0] bcd_a, bcd_c;
    logic [20:0] seg_a, seg_c;
    logic [19:0] bcd_b;
    logic [34:0] seg_b;

    exp_t q [N][$];
    int   cyc;
    int   checks;
    int   errors;
    logic prev_ov [N];

    bin_to_dec_7seg_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst(rst), .bin(bin_v[0][7:0]), .in_valid(in_valid[0]),
        .in_ready(rdy[0]), .bcd(bcd_a), .seg(seg_a), .out_valid(ov[0]));

    bin_to_dec_7seg_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)) u_c (
        .clk(clk), .rst(rst), .bin(bin_v[1][7:0]), .in_valid(in_valid[1]),
        .in_ready(rdy[1]), .bcd(bcd_c), .seg(seg_c), .out_valid(ov[1]));

    bin_to_dec_7seg_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst(rst), .bin(bin_v[2]), .in_valid(in_valid[2]),
        .in_ready(rdy[2]), .bcd(bcd_b), .seg(seg_b), .out_valid(ov[2]));

    assign bcd_o[0] = {8'h00, bcd_a};
    assign seg_o[0] = {14'h0000, seg_a};
    assign bcd_o[1] = {8'h00, bcd_c};
    assign seg_o[1] = {14'h0000, seg_c};
    assign bcd_o[2] = bcd_b;
    assign seg_o[2] = seg_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by repeated division, packed as BCD.
    function automatic logic [19:0] ref_bcd(input int v, input int nd);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Seven-segment image of the decimal number, from the display rules.
    function automatic logic [34:0] ref_seg(input int v, input int nd, input int blank, input int low);
        logic [6:0]  tbl [10];
        int          d   [5];
        int          hi;
        logic [6:0]  p;
        logic [34:0] r;
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        hi  = 0;
        r   = '0;
        for (int i = 0; i < nd; i++) begin
            d[i] = v % 10;
            v    = v / 10;
            if (d[i] != 0) hi = i;
        end
        for (int i = 0; i < nd; i++) begin
            p = (blank != 0 && i > hi) ? 7'h00 : tbl[d[i]];
            if (low != 0) p = ~p;
            r[7*i +: 7] = p;
        end
        return r;
    endfunction

    function automatic logic [34:0] seg_off(input int k);
        logic [34:0] r;
        r = '0;
        if (PSAL[k] != 0) begin
            for (int i = 0; i < 7*PD[k]; i++) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Present v with in_valid held until accepted; record expectation at acceptance.
    task automatic send(input int k, input int v, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bin_v[k]    = 16'(v);
        in_valid[k] = 1'b1;
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst %0d: in_ready stayed %b, expected 1", k, rdy[k]);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        @(posedge clk);
        e.bcd = ref_bcd(v, PD[k]);
        e.seg = ref_seg(v, PD[k], PBL[k], PSAL[k]);
        e.acc = acc;
        q[k].push_back(e);
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0",
                     q[0].size() + q[1].size() + q[2].size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each presented result with the scoreboard head.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (ov[k] === 1'b1) begin
                check($sformatf("out_valid_single_cycle[%0d]", k), 64'(prev_ov[k]), 64'd0);
                check($sformatf("in_ready_with_out_valid[%0d]", k), 64'(rdy[k]), 64'd1);
                if (q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid[%0d]: got bcd %h with nothing outstanding", k, bcd_o[k]);
                end else begin
                    exp_t e;
                    e = q[k].pop_front();
                    check($sformatf("bcd[%0d]", k), 64'(bcd_o[k]), 64'(e.bcd));
                    check($sformatf("seg[%0d]", k), 64'(seg_o[k]), 64'(e.seg));
                    check($sformatf("latency[%0d]", k), 64'(cyc - e.acc), 64'(PW[k]));
                end
            end else if (q[k].size() != 0) begin
                check($sformatf("in_ready_busy[%0d]", k), 64'(rdy[k]), 64'd0);
            end
            prev_ov[k] = ov[k];
        end
    end

    initial begin
        int a0, a1, v, gap;
        int vals_a[4] = '{255, 0, 7, 100};
        int vals_c[4] = '{7, 0, 255, 100};
        int vals_b[5] = '{65535, 7, 0, 10000, 1};

        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        for (int k = 0; k < N; k++) begin
            bin_v[k]    = '0;
            in_valid[k] = 1'b0;
            prev_ov[k]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("reset_in_ready[%0d]", k), 64'(rdy[k]), 64'd1);
            check($sformatf("reset_bcd[%0d]", k), 64'(bcd_o[k]), 64'd0);
            check($sformatf("reset_seg[%0d]", k), 64'(seg_o[k]), 64'(seg_off(k)));
            check($sformatf("reset_out_valid[%0d]", k), 64'(ov[k]), 64'd0);
        end
        rst = 1'b0;

        // Directed values per configuration, issued back to back.
        foreach (vals_a[i]) send(0, vals_a[i], a0);
        idle(0);
        foreach (vals_c[i]) send(1, vals_c[i], a0);
        idle(1);
        foreach (vals_b[i]) send(2, vals_b[i], a0);
        idle(2);
        drain();

        // New value held on in_valid during a conversion is taken right after it.
        send(0, 42, a0);
        send(0, 199, a1);
        idle(0);
        check("accept_after_conversion", 64'(a1 - a0), 64'(PW[0] + 1));
        drain();

        // Reset in the middle of a conversion aborts it.
        send(0, 123, a0);
        idle(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < N; k++) q[k].delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", 64'(bcd_o[0]), 64'd0);
        check("abort_seg", 64'(seg_o[0]), 64'd0);
        check("abort_in_ready", 64'(rdy[0]), 64'd1);
        check("abort_out_valid", 64'(ov[0]), 64'd0);
        repeat (PW[0] + 4) @(negedge clk);

        // Random values with random idle gaps.
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 15; t++) begin
                v = int'($urandom_range((1 << PW[k]) - 1, 0));
                send(k, v, a0);
                if ($urandom_range(1, 0) == 1) begin
                    idle(k);
                    gap = int'($urandom_range(PW[k] + 3, 0));
                    repeat (gap) @(negedge clk);
                end
            end
            idle(k);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_dec_7seg_seq.md
# bin_to_dec_7seg_seq

Sequential, parametrised binary-to-decimal seven-segment encoder. It accepts an unsigned WIDTH-bit value over a valid/ready handshake and converts it to DIGITS packed BCD digits by iterative shift-add-3 (double dabble), one bit per clock. It then registers both the BCD result and the per-digit segment patterns, with optional leading-zero blanking and selectable segment polarity. It sits between datapath logic and the board display drivers, where it replaces the fixed 8-bit, 3-digit combinational decoder.

## Interface
- WIDTH, 8: input binary width; must be ≥ 1.
- DIGITS, 3: number of decimal digits; must satisfy 10^DIGITS > 2^WIDTH−1, otherwise elaboration fails with $error.
- BLANK_LEADING, 1: 1 = leading-zero digits show all segments off; 0 = every digit shown.
- SEG_ACTIVE_LOW, 0: 1 = segment outputs are inverted, so 0 lights a segment.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- bin  in  WIDTH  unsigned value; sampled only on an accepted handshake.
- in_valid  in  1  bin is valid.
- in_ready  out  1  block can accept; high exactly when state is IDLE.
- bcd  out  4*DIGITS  packed BCD; digit i (10^i) occupies bits [4i+3:4i].
- seg  out  7*DIGITS  segments; digit i occupies bits [7i+6:7i], with bit order {g,f,e,d,c,b,a} (bit 0 = a).
- out_valid  out  1  one-cycle pulse when bcd/seg carry a new result.

## Operation
- States: IDLE, CONV.
- IDLE → CONV when in_valid && in_ready at a rising edge.
  - On that edge: load shift register {BCD field = 0, bin}; set bit counter = WIDTH.
- CONV behaviour, per edge:
  - Every BCD nibble ≥ 5 gets +3.
  - Then the whole {BCD, bin} register shifts left by 1.
  - Counter decrements.
- Completion happens on the edge where the counter goes 1 → 0. On that edge:
  - bcd and seg registers are updated from the final BCD field.
  - out_valid is set to 1 for the next cycle.
  - State returns to IDLE.
- bcd, seg and out_valid update only at completion; they hold the last result otherwise.
- Digit patterns 0..9 (active-high): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Nibble values > 9 cannot occur.
- Blanking (BLANK_LEADING=1):
  - Digit i > 0 is blanked when it and all higher digits are 0.
  - Digit 0 is never blanked, so value 0 displays "0".
  - Interior zeros are displayed.
- A blanked digit drives all-segments-off: 7'h00 when active-high, 7'h7F when SEG_ACTIVE_LOW=1.
- SEG_ACTIVE_LOW inverts every segment bit after blanking.
- in_valid while in CONV is ignored; there is no queueing, and bin is not re-sampled.
- The bcd output is never blanked or inverted.

## Timing
- Reset values, one edge after rst is high:
  - state = IDLE, so in_ready = 1.
  - bcd = 0, out_valid = 0.
  - seg = all segments off (0 active-high, all-ones active-low).
- rst mid-CONV aborts the conversion. No out_valid pulse follows; outputs take reset values.
- rst has priority over a simultaneous handshake.
- Latency: accept at edge E0 → results registered at edge E0+WIDTH → out_valid high during the cycle after E0+WIDTH.
- in_ready returns to 1 in the same cycle as out_valid. A new value held on in_valid is accepted at edge E0+WIDTH+1.
- Maximum throughput is therefore one conversion per WIDTH+1 cycles.
- out_valid is never high for two consecutive cycles.
- in_ready is never high while in CONV.

## Test plan
- Defaults; rst, then bin=255 accepted at edge E0:
  - in_ready = 0 for 8 cycles.
  - At E0+8: bcd = 12'h255, seg = {5B,6D,6D} (digit2..digit0).
  - out_valid pulses one cycle; in_ready returns to 1.
- Defaults; bin=0, then bin=7, then bin=100:
  - 0 → seg {00,00,3F}.
  - 7 → {00,00,07}.
  - 100 → {06,3F,3F} (interior zeros shown).
- BLANK_LEADING=0, SEG_ACTIVE_LOW=1, bin=7:
  - bcd = 12'h007, seg = {40,40,78}.
- Defaults; bin=42 accepted; during CONV, drive bin=199 with in_valid held high:
  - Result is bcd = 12'h042.
  - 199 is accepted at E0+9, and its result bcd = 12'h199 arrives at E0+17.
- Defaults; accept bin=123, then assert rst for one cycle 4 cycles later:
  - No out_valid pulse.
  - bcd = 0, seg = 0, in_ready = 1 after reset.
- WIDTH=16, DIGITS=5, bin=65535:
  - bcd = 20'h65535 after exactly 16 cycles.
  - seg = {7D,6D,6D,4F,6D}.
- Also: WIDTH=16 with DIGITS=4 fails elaboration.
